biassram_r: RTL
===============

# biassram_r

Bias SRAM read engine: the read-side counterpart of the bias SRAM writer. Performs the first-read handshake the writer requests once a layer's biases are stored, then serves one 32-bit bias per output channel to the accumulator/post-processing stage, advancing on consumer request and wrapping at the configured layer length. Drives the read side of bias SRAM_0. The SRAM has 1-cycle read latency.

## Interface
Parameters:
- ADDR_CNT_BITS, 9, bias SRAM address/index width
- BIAS_SRAM_WLEN, 32, bias word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bias_rd1st_start  in  1  first-read request from writer; may stay high up to 2 cycles
- bias_rd1st_busy  out  1  first read in progress
- bias_rd1st_done  out  1  1-cycle pulse, first bias loaded
- cen_biasr_0  out  1  SRAM chip enable, active low
- wen_biasr_0  out  1  SRAM write enable, active low; tied 1 (read only)
- addr_biasr_0  out  ADDR_CNT_BITS  SRAM read address
- dout_biasr_0  in  BIAS_SRAM_WLEN  SRAM read data, valid the cycle after cen low
- cfg_bir_lengthsub1  in  ADDR_CNT_BITS  number of biases minus 1; static while not IDLE
- bias_next  in  1  consumer has used the current bias
- bias_valid  out  1  bias_data holds a valid bias
- bias_data  out  BIAS_SRAM_WLEN  current bias
- bias_idx  out  ADDR_CNT_BITS  index of current bias
- bias_last  out  1  bias_idx == cfg_bir_lengthsub1

## Operation
- States: IDLE, FETCH (cen low, addr driven), CAPTURE (latch dout into bias_data), READY.
- IDLE: start -> FETCH with addr 0; busy rises.
- FETCH -> CAPTURE unconditionally; CAPTURE -> READY. First-read completion asserts done for one cycle on entry to READY.
- busy is high in FETCH, CAPTURE and the done cycle, so the writer's registered start deasserts before busy falls.
- READY: bias_valid=1. bias_next -> idx = (idx==lengthsub1) ? 0 : idx+1; then FETCH/CAPTURE again (no done pulse, busy stays low).
- start is accepted in IDLE and READY (new layer: reload from addr 0, first-read handshake repeats). It is ignored in FETCH/CAPTURE.
- bias_next is ignored when bias_valid=0.
- If start and bias_next arrive in the same cycle, start wins.
- Reset is allowed at any time and returns the block to IDLE with all outputs at reset values.
- Reset values: busy 0, done 0, cen 1, wen 1, addr 0, bias_valid 0, bias_data 0, bias_idx 0, bias_last 0 (bias_last = 1 when lengthsub1 = 0 and bias_valid = 1).

## Timing
- start sampled at cycle T -> cen low / addr 0 at T+1 -> data captured at the end of T+2 -> bias_valid=1, done=1 at T+3; busy high T+1..T+3.
- Without prefetch: bias_next at cycle N -> bias_valid low at N+1..N+2, new bias valid at N+3.
- Length 1 (lengthsub1=0): bias_next re-fetches addr 0 and bias_last stays 1.

## Configuration
- BIAS_PREFETCH_EN defined:
  - A shadow register holds the bias at (idx+1) wrapped. The prefetch issues automatically whenever the shadow is empty and the state is READY.
  - bias_next with a full shadow swaps it in the same cycle: zero bubble, bias_valid stays 1.
  - bias_next with an empty shadow drops bias_valid until the fetch lands.
  - start flushes the shadow.
- BIAS_PREFETCH_EN undefined: no shadow; timing is as listed under Timing.

## Structure
- Shared package bias_pkg: state encoding constants, BIAS_SRAM_WLEN, default ADDR_CNT_BITS.
- One sub-module: count_yi_v4 as the index counter (enable = advance, final_number = cfg_bir_lengthsub1, last -> bias_last). It is separately cleared on start.

## Test plan
- Reset then start pulse with lengthsub1=3, SRAM holding 0x10,0x11,0x12,0x13 -> done at T+3, bias_data=0x10, idx 0, busy high exactly 3 cycles.
- Writer-style start held 2 cycles -> exactly one FETCH of addr 0, one done pulse.
- Four bias_next pulses, spaced wide apart -> data 0x11,0x12,0x13,0x10; bias_last high only at idx 3; wrap to 0.
- Back-to-back bias_next with BIAS_PREFETCH_EN -> first advance zero bubble; second stalls bias_valid until the fetch lands. Without the macro -> 2-cycle bubble each.
- Start in READY at idx 2 plus a simultaneous bias_next -> reload from addr 0, done pulse, bias_next discarded.
- Reset asserted during CAPTURE -> all outputs at reset values the next cycle; a subsequent start works normally.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared definitions for the bias SRAM read engine: state encoding and default widths.
package bias_pkg;

    localparam int unsigned BIAS_SRAM_WLEN_DEF = 32;
    localparam int unsigned ADDR_CNT_BITS_DEF  = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READY   = 2'd3
    } bir_state_e;

endpackage

// File: rtl/biassram_r_if.sv
// Bus bundle for biassram_r: writer handshake, SRAM read port, config and consumer side.
interface biassram_r_if
    import bias_pkg::*;
#(
    parameter int unsigned ADDR_CNT_BITS  = ADDR_CNT_BITS_DEF,
    parameter int unsigned BIAS_SRAM_WLEN = BIAS_SRAM_WLEN_DEF
);
    logic                      bias_rd1st_start;
    logic                      bias_rd1st_busy;
    logic                      bias_rd1st_done;
    logic                      cen_biasr_0;
    logic                      wen_biasr_0;
    logic [ADDR_CNT_BITS-1:0]  addr_biasr_0;
    logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0;
    logic [ADDR_CNT_BITS-1:0]  cfg_bir_lengthsub1;
    logic                      bias_next;
    logic                      bias_valid;
    logic [BIAS_SRAM_WLEN-1:0] bias_data;
    logic [ADDR_CNT_BITS-1:0]  bias_idx;
    logic                      bias_last;

    modport slave (
        input  bias_rd1st_start, dout_biasr_0, cfg_bir_lengthsub1, bias_next,
        output bias_rd1st_busy, bias_rd1st_done, cen_biasr_0, wen_biasr_0,
               addr_biasr_0, bias_valid, bias_data, bias_idx, bias_last
    );

    modport master (
        output bias_rd1st_start, dout_biasr_0, cfg_bir_lengthsub1, bias_next,
        input  bias_rd1st_busy, bias_rd1st_done, cen_biasr_0, wen_biasr_0,
               addr_biasr_0, bias_valid, bias_data, bias_idx, bias_last
    );

endinterface

// File: rtl/count_yi_v4.sv
// Wrapping index counter: counts 0..final_number_i, clear has priority over enable.
module count_yi_v4 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] final_number_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == final_number_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/biassram_r.sv
// Bias SRAM read engine: first-read handshake, then one bias per channel on consumer request.
// Optional BIAS_PREFETCH_EN adds a one-entry shadow holding the bias at the next index.
module biassram_r
    import bias_pkg::*;
#(
    parameter int unsigned ADDR_CNT_BITS  = ADDR_CNT_BITS_DEF,
    parameter int unsigned BIAS_SRAM_WLEN = BIAS_SRAM_WLEN_DEF
) (
    input logic         clk,
    input logic         reset,
    biassram_r_if.slave bus
);

    bir_state_e                state_q, state_d;
    logic                      rd1st_q, rd1st_d;
    logic [BIAS_SRAM_WLEN-1:0] data_q, data_d;

    logic                      start_acc;
    logic                      advance;
    logic [ADDR_CNT_BITS-1:0]  idx;
    logic                      idx_last;

    logic                      cen;
    logic [ADDR_CNT_BITS-1:0]  addr;
    logic                      busy;
    logic                      done;
    logic                      valid;

`ifdef BIAS_PREFETCH_EN
    logic [BIAS_SRAM_WLEN-1:0] shadow_q, shadow_d;
    logic                      shadow_vld_q, shadow_vld_d;
    logic                      pf_inflight_q, pf_inflight_d;
    logic [ADDR_CNT_BITS-1:0]  idx_nxt;

    assign idx_nxt = idx_last ? '0 : idx + ADDR_CNT_BITS'(1);
`endif

    // start is only honoured when no SRAM read is outstanding; it beats bias_next
    assign start_acc = bus.bias_rd1st_start && (state_q == ST_IDLE || state_q == ST_READY);
    assign advance   = bus.bias_next && (state_q == ST_READY) && !start_acc;

    count_yi_v4 #(
        .WIDTH (ADDR_CNT_BITS)
    ) u_idx_cnt (
        .clk            (clk),
        .reset          (reset),
        .clr_i          (start_acc),
        .en_i           (advance),
        .final_number_i (bus.cfg_bir_lengthsub1),
        .cnt_o          (idx),
        .last_o         (idx_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_acc) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_READY;
            ST_READY: begin
                if (start_acc) begin
                    state_d = ST_FETCH;
`ifdef BIAS_PREFETCH_EN
                end else if (advance && !shadow_vld_q && !pf_inflight_q) begin
`else
                end else if (advance) begin
`endif
                    state_d = ST_FETCH;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cen     = 1'b1;
        addr    = '0;
        busy    = rd1st_q && (state_q != ST_IDLE);
        done    = 1'b0;
        valid   = 1'b0;
        data_d  = data_q;
        rd1st_d = rd1st_q;
`ifdef BIAS_PREFETCH_EN
        shadow_d      = shadow_q;
        shadow_vld_d  = shadow_vld_q;
        pf_inflight_d = 1'b0;
`endif
        if (start_acc) begin
            rd1st_d = 1'b1;
        end else if (state_q == ST_READY) begin
            rd1st_d = 1'b0;
        end

        unique case (state_q)
            ST_FETCH: begin
                cen  = 1'b0;
                addr = idx;
            end
            ST_CAPTURE: data_d = bus.dout_biasr_0;
            ST_READY: begin
                valid = 1'b1;
                done  = rd1st_q;
`ifdef BIAS_PREFETCH_EN
                // An advance that coincides with a landing prefetch takes the SRAM data directly
                if (start_acc) begin
                    shadow_vld_d = 1'b0;
                end else if (advance) begin
                    if (shadow_vld_q) begin
                        data_d       = shadow_q;
                        shadow_vld_d = 1'b0;
                    end else if (pf_inflight_q) begin
                        data_d = bus.dout_biasr_0;
                    end
                end else if (pf_inflight_q) begin
                    shadow_d     = bus.dout_biasr_0;
                    shadow_vld_d = 1'b1;
                end else if (!shadow_vld_q) begin
                    cen           = 1'b0;
                    addr          = idx_nxt;
                    pf_inflight_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd1st_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rd1st_q <= rd1st_d;
            data_q  <= data_d;
        end
    end

`ifdef BIAS_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            shadow_vld_q  <= 1'b0;
            pf_inflight_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_vld_q  <= shadow_vld_d;
            pf_inflight_q <= pf_inflight_d;
        end
    end
`endif

    assign bus.bias_rd1st_busy = busy;
    assign bus.bias_rd1st_done = done;
    assign bus.cen_biasr_0     = cen;
    assign bus.wen_biasr_0     = 1'b1;
    assign bus.addr_biasr_0    = addr;
    assign bus.bias_valid      = valid;
    assign bus.bias_data       = data_q;
    assign bus.bias_idx        = idx;
    assign bus.bias_last       = idx_last && (state_q != ST_IDLE);

endmodule
